six_bit_accumulator_ctrl: RTL and testbench

//   Sequential front-end/back-end stage for the external 6-bit ripple adder.

---
 rtl/six_bit_accumulator_ctrl.sv | 144 ++++++++++++++
 tb/tb_six_bit_accumulator_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/six_bit_accumulator_ctrl.sv
// Operand sequencer around an external WIDTH-bit adder: streams operands in, folds sums into acc, hands off the total.
// Optional build macro: SATURATE_EN (acc clamps to all-ones after the first carry-out).
module six_bit_accumulator_ctrl #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] adder_x,
    output logic [WIDTH-1:0] adder_y,
    input  logic [WIDTH-1:0] adder_z,
    input  logic             adder_carry,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] acc_beat;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;

    // Value acc takes on an accepted beat.
`ifdef SATURATE_EN
    assign acc_beat = (adder_carry || ovf_q) ? {WIDTH{1'b1}} : adder_z;
`else
    assign acc_beat = adder_z;
`endif

    assign cnt_inc = CNT_W'(cnt_q + 1'b1);
    assign beat    = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; handshake outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    len_d  = len;
                    busy_d = 1'b1;
                    if (len == '0) begin
                        state_d     = S_DONE;
                        sum_d       = '0;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end else begin
                        state_d    = S_ACC;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (beat) begin
                    acc_d = acc_beat;
                    ovf_d = ovf_q | adder_carry;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d     = S_DONE;
                        sum_d       = acc_beat;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign adder_x   = acc_q;
    assign adder_y   = in_data;
    assign sum       = sum_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_six_bit_accumulator_ctrl.sv
// Directed bench for six_bit_accumulator_ctrl with a behavioural ripple adder beside the DUT and a result scoreboard.
module tb_six_bit_accumulator_ctrl;

    typedef struct packed {
        logic [5:0] s;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] adder_x;
    logic [5:0] adder_y;
    logic [5:0] adder_z;
    logic       adder_carry;
    logic [5:0] sum;
    logic       overflow;
    logic       out_valid;
    logic       out_ready;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // External adder model, instantiated beside the controller.
    assign {adder_carry, adder_z} = {1'b0, adder_x} + {1'b0, adder_y};

    six_bit_accumulator_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .adder_x    (adder_x),
        .adder_y    (adder_y),
        .adder_z    (adder_z),
        .adder_carry(adder_carry),
        .sum        (sum),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned ops[$]);
        logic [6:0] t;
        logic [5:0] a;
        logic       o;
        a = '0;
        o = 1'b0;
        foreach (ops[i]) begin
            t = {1'b0, a} + {1'b0, 6'(ops[i])};
`ifdef SATURATE_EN
            a = (o || t[6]) ? 6'h3f : t[5:0];
`else
            a = t[5:0];
`endif
            o = o | t[6];
        end
        return '{s: a, o: o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int unsigned l);
        start = 1'b1;
        len   = 4'(l);
        tick();
        start = 1'b0;
        len   = 4'($urandom_range(0, 15));
    endtask

    task automatic send(input int unsigned v, input int unsigned gap);
        int k;
        repeat (gap) tick();
        in_data  = 6'(v);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 6'($urandom_range(0, 63));
    endtask

    // Result must be present right after the final beat; compare, then hand off.
    task automatic collect(input string tag, input int unsigned hold);
        exp_t e;
        chk({tag, "_valid_latency"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        repeat (hold) begin
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(sum), 32'(e.s));
            start = 1'b1;
            len   = 4'd2;
            tick();
            start = 1'b0;
        end
        chk({tag, "_sum"}, 32'(sum), 32'(e.s));
        chk({tag, "_ovf"}, 32'(overflow), 32'(e.o));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 10+20+30
        sb.push_back(model('{10, 20, 30}));
        do_start(3);
        chk("t1_busy", 32'(busy), 32'd1);
        send(10, 0);
        send(20, 0);
        chk("t1_no_early_valid", 32'(out_valid), 32'd0);
        send(30, 0);
        collect("t1", 0);

        // 40+30 wraps with carry
        sb.push_back(model('{40, 30}));
        do_start(2);
        send(40, 0);
        send(30, 0);
        collect("t2", 0);

        // len 0 goes straight to the result
        sb.push_back(model('{}));
        do_start(0);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        collect("t3", 2);

        // Gapped beats, ignored start pulses, held result
        sb.push_back(model('{1, 2, 3, 4}));
        do_start(4);
        send(1, 0);
        start = 1'b1;
        len   = 4'd1;
        send(2, 2);
        start = 1'b0;
        send(3, 2);
        send(4, 2);
        collect("t4", 5);

        // Reset mid-accumulation
        sb.push_back(model('{9, 9, 9, 9, 9}));
        do_start(5);
        send(9, 0);
        send(9, 0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_sum", 32'(sum), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        chk("t5_rst_acc", 32'(adder_x), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sb.push_back(model('{7}));
        do_start(1);
        send(7, 0);
        collect("t5", 0);

        // Back-to-back, overflow cleared at each start (preceded by an overflowing run)
        sb.push_back(model('{63, 63}));
        do_start(2);
        send(63, 0);
        send(63, 0);
        collect("t6a", 0);
        sb.push_back(model('{63}));
        do_start(1);
        send(63, 0);
        collect("t6b", 0);
        sb.push_back(model('{1}));
        do_start(1);
        send(1, 0);
        collect("t6c", 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
